// File: rtl/spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_queue
// Purpose  : Queues host words into a TX FIFO, launches them one at a time
//            to an SPI master, watches for completion with a timeout, and
//            optionally buffers received words in an RX FIFO.
// Options  : define SPI_XFER_QUEUE_RX_EN to build the RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_queue #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       m_start_tx,
    output logic [DATA_WIDTH-1:0]      m_tx_data,
    input  logic                       m_busy,
    input  logic                       m_irq,
    input  logic [DATA_WIDTH-1:0]      m_rx_data,
    output logic                       r_valid,
    input  logic                       r_ready,
    output logic [DATA_WIDTH-1:0]      r_data,
    output logic [$clog2(DEPTH):0]     tx_level,
    output logic                       timeout_err,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [CW-1:0]         wait_cnt;
    logic                  launch_ok;
    logic                  done_irq;
    logic                  timeout_hit;
    logic                  rx_space;

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [AW-1:0]         tx_wr_ptr;
    logic [AW-1:0]         tx_rd_ptr;
    logic [LW-1:0]         tx_count;
    logic                  tx_push;
    logic                  tx_pop;

    // Ready comes from the registered level only, so a full FIFO never
    // accepts a word even while a launch is popping in the same cycle.
    assign s_ready  = (tx_count < LEVEL_FULL);
    assign tx_push  = s_valid && s_ready;
    assign tx_pop   = m_start_tx;
    assign tx_level = tx_count;

    // TX storage write; contents need no reset, the level tracks validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= s_data;
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + LW'(1);
                2'b01:   tx_count <= tx_count - LW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- RX FIFO (optional) ----------------
`ifdef SPI_XFER_QUEUE_RX_EN
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]         rx_wr_ptr;
    logic [AW-1:0]         rx_rd_ptr;
    logic [LW-1:0]         rx_count;
    logic                  rx_push;
    logic                  rx_pop;

    assign rx_space = (rx_count != LEVEL_FULL);
    assign rx_push  = done_irq && rx_space;
    assign rx_pop   = r_valid && r_ready;
    assign r_valid  = (rx_count != '0);
    assign r_data   = r_valid ? rx_mem[rx_rd_ptr] : '0;

    // RX storage write of the word returned with the completion pulse.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= m_rx_data;
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + LW'(1);
                2'b01:   rx_count <= rx_count - LW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic unused_rx_inputs;

    assign rx_space         = 1'b1;
    assign r_valid          = 1'b0;
    assign r_data           = '0;
    assign unused_rx_inputs = ^{m_rx_data, r_ready};
`endif

    // ---------------- Transfer FSM ----------------
    assign launch_ok = (tx_count != '0) && !m_busy && !timeout_err && rx_space;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; one transfer outstanding at a time.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (launch_ok) next_state = ST_LAUNCH;
            ST_LAUNCH: next_state = ST_WAIT;
            ST_WAIT:   if (m_irq || (wait_cnt == CNT_LAST)) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // FSM outputs; completion beats timeout when both land together.
    always_comb begin
        m_start_tx  = 1'b0;
        done_irq    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_LAUNCH: m_start_tx = 1'b1;
            ST_WAIT: begin
                done_irq    = m_irq;
                timeout_hit = !m_irq && (wait_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    // Launch word register: loaded on the way into LAUNCH, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             m_tx_data <= '0;
        else if ((state == ST_IDLE) && launch_ok) m_tx_data <= tx_mem[tx_rd_ptr];
    end

    // Completion wait counter, zero outside WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          wait_cnt <= '0;
        else if ((state == ST_WAIT) && (next_state == ST_WAIT)) wait_cnt <= wait_cnt + CW'(1);
        else                                                 wait_cnt <= '0;
    end

    // Sticky timeout flag; a new timeout outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           timeout_err <= 1'b0;
        else if (timeout_hit) timeout_err <= 1'b1;
        else if (clr_err)     timeout_err <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_queue
// Purpose  : Directed self-checking bench for spi_xfer_queue (16-bit, depth
//            16, timeout 4096). RX checks follow SPI_XFER_QUEUE_RX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        m_busy = 1'b0;
    logic        m_irq = 1'b0;
    logic [15:0] m_rx_data = '0;
    logic        r_ready = 1'b0;
    logic        clr_err = 1'b0;
    logic        s_ready;
    logic        m_start_tx;
    logic [15:0] m_tx_data;
    logic        r_valid;
    logic [15:0] r_data;
    logic [4:0]  tx_level;
    logic        timeout_err;

    int passed = 0;
    int total  = 0;
    int starts = 0;
    bit rv_seen = 1'b0;

    spi_xfer_queue #(.DATA_WIDTH(16), .DEPTH(16), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_start_tx(m_start_tx), .m_tx_data(m_tx_data),
        .m_busy(m_busy), .m_irq(m_irq), .m_rx_data(m_rx_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .tx_level(tx_level), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; samples 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_start_tx === 1'b1) starts++;
        if (r_valid !== 1'b0) rv_seen = 1'b1;
    endtask

    task automatic push(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (m_start_tx !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(m_start_tx), 1);
    endtask

    // Called while in LAUNCH: move to WAIT_DONE, then complete with ~d.
    task automatic respond(input logic [15:0] d);
        tick();
        m_irq     = 1'b1;
        m_rx_data = ~d;
        tick();
        m_irq     = 1'b0;
    endtask

    task automatic rx_pop_check(input string tag, input logic [15:0] e);
        check(tag, 32'(r_data), 32'(e));
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        int s0;

        // Reset values
        repeat (3) tick();
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_tx_level", 32'(tx_level), 0);
        check("rst_start", 32'(m_start_tx), 0);
        check("rst_tx_data", 32'(m_tx_data), 0);
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_r_data", 32'(r_data), 0);
        check("rst_err", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick();

        // Two words, master echoes the complement
        m_busy = 1'b1;
        push(16'hA5A5);
        push(16'h1234);
        check("two_level", 32'(tx_level), 2);
        check("busy_no_start", 32'(starts), 0);
        m_busy = 1'b0;
        wait_start("start_a5a5");
        check("data_a5a5", 32'(m_tx_data), 32'h0000A5A5);
        tick();
        check("start_one_cycle", 32'(m_start_tx), 0);
        check("data_hold", 32'(m_tx_data), 32'h0000A5A5);
        m_irq = 1'b1;
        m_rx_data = 16'h5A5A;
        tick();
        m_irq = 1'b0;
        wait_start("start_1234");
        check("data_1234", 32'(m_tx_data), 32'h00001234);
        respond(16'h1234);
`ifdef SPI_XFER_QUEUE_RX_EN
        rx_pop_check("rx_5a5a", 16'h5A5A);
        rx_pop_check("rx_edcb", 16'hEDCB);
`endif
        check("rx_empty_after_two", 32'(r_valid), 0);

        // Fill the TX FIFO while the master is busy
        m_busy = 1'b1;
        s0 = starts;
        for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
        check("full_level", 32'(tx_level), 16);
        check("full_s_ready", 32'(s_ready), 0);
        push(16'hDEAD);
        check("full_reject", 32'(tx_level), 16);
        check("full_no_start", 32'(starts - s0), 0);
        // Launch pops while full: still not ready, so the held word is refused
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        m_busy  = 1'b0;
        tick();
        check("full_launch", 32'(m_start_tx), 1);
        check("full_pop_ready", 32'(s_ready), 0);
        check("full_first", 32'(m_tx_data), 32'h00001000);
        tick();
        s_valid = 1'b0;
        check("pop_no_pass", 32'(tx_level), 15);
        m_irq = 1'b1;
        m_rx_data = ~16'h1000;
        tick();
        m_irq = 1'b0;
        for (int i = 1; i < 16; i++) begin
            wait_start("drain_start");
            check("drain_order", 32'(m_tx_data), 32'(16'h1000 + 16'(i)));
            respond(16'h1000 + 16'(i));
        end
        check("drain_level", 32'(tx_level), 0);

`ifdef SPI_XFER_QUEUE_RX_EN
        // RX full blocks launches until one word is read
        push(16'h7777);
        s0 = starts;
        repeat (20) tick();
        check("rx_full_block", 32'(starts - s0), 0);
        rx_pop_check("rx_full_head", ~16'h1000);
        wait_start("rx_unblock");
        check("rx_unblock_data", 32'(m_tx_data), 32'h00007777);
        respond(16'h7777);
        for (int i = 1; i < 16; i++) begin
            w = ~(16'h1000 + 16'(i));
            rx_pop_check("rx_drain", w);
        end
        rx_pop_check("rx_last", ~16'h7777);
        check("rx_drained", 32'(r_valid), 0);
`endif

        // Completion on the last counted cycle wins over timeout
        push(16'h0101);
        wait_start("start_0101");
        repeat (4096) tick();
        m_irq = 1'b1;
        m_rx_data = ~16'h0101;
        tick();
        m_irq = 1'b0;
        check("irq_at_limit", 32'(timeout_err), 0);

        // Timeout, launch lockout, clear
        push(16'h0202);
        wait_start("start_0202");
        repeat (4096) tick();
        check("pre_timeout", 32'(timeout_err), 0);
        tick();
        check("timeout_set", 32'(timeout_err), 1);
        s0 = starts;
        push(16'h0303);
        repeat (10) tick();
        check("err_no_launch", 32'(starts - s0), 0);
        check("err_level", 32'(tx_level), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_cleared", 32'(timeout_err), 0);
        wait_start("start_0303");
        check("data_0303", 32'(m_tx_data), 32'h00000303);
        respond(16'h0303);
`ifdef SPI_XFER_QUEUE_RX_EN
        rx_pop_check("rx_0101", ~16'h0101);
        rx_pop_check("rx_0303", ~16'h0303);
`endif

        // Reset in WAIT_DONE; a late completion is ignored
        push(16'h0404);
        wait_start("start_0404");
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_tx_data", 32'(m_tx_data), 0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        m_irq = 1'b1;
        m_rx_data = 16'h4321;
        tick();
        m_irq = 1'b0;
        tick();
        check("post_rst_r_valid", 32'(r_valid), 0);
        check("post_rst_r_data", 32'(r_data), 0);
        check("post_rst_start", 32'(m_start_tx), 0);
        check("post_rst_tx_data", 32'(m_tx_data), 0);
        check("post_rst_level", 32'(tx_level), 0);
        check("post_rst_ready", 32'(s_ready), 1);
        check("post_rst_err", 32'(timeout_err), 0);

        // Three words, three launches
        m_busy = 1'b1;
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        check("three_level", 32'(tx_level), 3);
        m_busy = 1'b0;
        s0 = starts;
        for (int i = 1; i <= 3; i++) begin
            w = 16'(i) * 16'h0011;
            wait_start("three_start");
            check("three_data", 32'(m_tx_data), 32'(w));
            respond(w);
        end
        check("three_count", 32'(starts - s0), 3);
`ifdef SPI_XFER_QUEUE_RX_EN
        for (int i = 1; i <= 3; i++) begin
            w = ~(16'(i) * 16'h0011);
            rx_pop_check("three_rx", w);
        end
`else
        check("no_rx_valid_ever", 32'(rv_seen), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
